// File: rtl/mod_99_verify_ctrl_if.sv
// Handshake bundle between the verify/respond controller and the TX/RX processing blocks.
// master = controller side (drives the send requests), slave = TX/RX side.
interface mod_99_verify_ctrl_if;
    logic rcv_v;
    logic rcv_r;
    logic send_v_ack;
    logic send_r_ack;
    logic send_v;
    logic send_r;

    modport master (
        input  rcv_v, rcv_r, send_v_ack, send_r_ack,
        output send_v, send_r
    );

    modport slave (
        output rcv_v, rcv_r, send_v_ack, send_r_ack,
        input  send_v, send_r
    );
endinterface

// File: rtl/mod_99_verify_ctrl.sv
// MAC Merge verify/respond controller: sequences verify mPackets, times responses,
// and reports preemption activity and verification status to TX and management.
module mod_99_verify_ctrl #(
    parameter int unsigned VERIFY_TIME_CYC = 8000,
    parameter int unsigned VERIFY_LIMIT    = 3,
    parameter int unsigned TMR_W           = 13
) (
    input  logic                      clk,
    input  logic                      reset_begin,
    input  logic                      pEnable,
    input  logic                      disableVerify,
    input  logic                      link_fail,
    mod_99_verify_ctrl_if.master      bus,
    output logic                      pActive,
    output logic [2:0]                verify_status,
    output logic [2:0]                verifyCnt,
    output logic [2:0]                verify_state
);

    localparam int unsigned CNT_W = 3;
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(VERIFY_TIME_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(VERIFY_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [2:0] ST_INITIAL   = 3'd0;
    localparam logic [2:0] ST_VERIFYING = 3'd1;
    localparam logic [2:0] ST_SUCCEEDED = 3'd2;
    localparam logic [2:0] ST_FAILED    = 3'd3;
    localparam logic [2:0] ST_DISABLED  = 3'd4;

    typedef enum logic [2:0] {
        INIT_VERIFICATION = 3'd0,
        SEND_VERIFY       = 3'd1,
        WAIT_FOR_RESPONSE = 3'd2,
        VERIFIED          = 3'd3,
        VERIFY_FAIL       = 3'd4,
        VERIFY_DISABLED   = 3'd5
    } state_t;

    state_t           state, nextState;
    logic [TMR_W-1:0] timer, timerNext;
    logic [CNT_W-1:0] cntQ, cntNext;
    logic             sendVQ, sendVNext;
    logic             sendRQ, sendRNext;
    logic             pActiveQ, pActiveNext;
    logic [2:0]       statusQ, statusNext;
    logic             abort;

    assign bus.send_v    = sendVQ;
    assign bus.send_r    = sendRQ;
    assign pActive       = pActiveQ;
    assign verify_status = statusQ;
    assign verifyCnt     = cntQ;
    assign verify_state  = state;

    always_ff @(posedge clk) begin
        if (reset_begin) begin
            state    <= INIT_VERIFICATION;
            timer    <= '0;
            cntQ     <= '0;
            sendVQ   <= 1'b0;
            sendRQ   <= 1'b0;
            pActiveQ <= 1'b0;
            statusQ  <= ST_INITIAL;
        end else begin
            state    <= nextState;
            timer    <= timerNext;
            cntQ     <= cntNext;
            sendVQ   <= sendVNext;
            sendRQ   <= sendRNext;
            pActiveQ <= pActiveNext;
            statusQ  <= statusNext;
        end
    end

    always_comb begin
        nextState   = state;
        timerNext   = timer;
        cntNext     = cntQ;
        sendVNext   = 1'b0;
        sendRNext   = sendRQ;
        pActiveNext = 1'b0;
        statusNext  = ST_INITIAL;
        abort       = link_fail || !pEnable;

        if (abort) begin
            nextState = INIT_VERIFICATION;
            timerNext = '0;
            cntNext   = '0;
        end else begin
            unique case (state)
                INIT_VERIFICATION: begin
                    cntNext   = '0;
                    nextState = disableVerify ? VERIFY_DISABLED : SEND_VERIFY;
                end
                SEND_VERIFY: begin
                    if (disableVerify) begin
                        nextState = VERIFY_DISABLED;
                    end else if (bus.send_v_ack) begin
                        cntNext   = (cntQ == CNT_MAX) ? cntQ : cntQ + CNT_W'(1);
                        timerNext = TMR_LOAD;
                        nextState = WAIT_FOR_RESPONSE;
                    end
                end
                WAIT_FOR_RESPONSE: begin
                    // A response landing on the timeout cycle still counts as success
                    if (disableVerify) begin
                        nextState = VERIFY_DISABLED;
                    end else if (bus.rcv_r) begin
                        nextState = VERIFIED;
                    end else if (timer == '0) begin
                        nextState = (cntQ < CNT_LIMIT) ? SEND_VERIFY : VERIFY_FAIL;
                    end else begin
                        timerNext = timer - TMR_W'(1);
                    end
                end
                VERIFIED, VERIFY_FAIL: nextState = state;
                VERIFY_DISABLED: begin
                    if (!disableVerify) nextState = INIT_VERIFICATION;
                end
                default: nextState = INIT_VERIFICATION;
            endcase
        end

        // Outputs are a function of the state being entered so they register in step with it
        unique case (nextState)
            SEND_VERIFY: begin
                sendVNext  = 1'b1;
                statusNext = ST_VERIFYING;
            end
            WAIT_FOR_RESPONSE: statusNext = ST_VERIFYING;
            VERIFIED: begin
                pActiveNext = 1'b1;
                statusNext  = ST_SUCCEEDED;
            end
            VERIFY_FAIL: statusNext = ST_FAILED;
            VERIFY_DISABLED: begin
                pActiveNext = 1'b1;
                statusNext  = ST_DISABLED;
            end
            default: statusNext = ST_INITIAL;
        endcase

        // Respond request: a new verify wins over a same-cycle ack; repeats merge
        if (abort) begin
            sendRNext = 1'b0;
        end else if (bus.rcv_v) begin
            sendRNext = 1'b1;
        end else if (bus.send_r_ack) begin
            sendRNext = 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_99_verify_ctrl.sv
// Directed bench for the MAC Merge verify/respond controller with a short timeout
// (8 cycles) and a verify limit of 3.
module tb_mod_99_verify_ctrl;

    logic       clk = 1'b0;
    logic       reset_begin;
    logic       pEnable;
    logic       disableVerify;
    logic       link_fail;
    logic       pActive;
    logic [2:0] verify_status;
    logic [2:0] verifyCnt;
    logic [2:0] verify_state;

    int vecCnt = 0;
    int errCnt = 0;

    mod_99_verify_ctrl_if bus ();

    mod_99_verify_ctrl #(
        .VERIFY_TIME_CYC(8),
        .VERIFY_LIMIT   (3),
        .TMR_W          (13)
    ) dut (
        .clk          (clk),
        .reset_begin  (reset_begin),
        .pEnable      (pEnable),
        .disableVerify(disableVerify),
        .link_fail    (link_fail),
        .bus          (bus.master),
        .pActive      (pActive),
        .verify_status(verify_status),
        .verifyCnt    (verifyCnt),
        .verify_state (verify_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_begin    = 1'b1;
        pEnable        = 1'b0;
        disableVerify  = 1'b0;
        link_fail      = 1'b0;
        bus.rcv_v      = 1'b0;
        bus.rcv_r      = 1'b0;
        bus.send_v_ack = 1'b0;
        bus.send_r_ack = 1'b0;
        step();
        reset_begin = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        vecCnt++;
        if ({bus.send_v, bus.send_r, pActive, verify_status, verifyCnt, verify_state} !== 12'h000) begin
            errCnt++;
            $display("FAIL reset_outputs: got v=%b r=%b act=%b st=%0d cnt=%0d fsm=%0d, want all 0",
                     bus.send_v, bus.send_r, pActive, verify_status, verifyCnt, verify_state);
        end
    endtask

    task automatic test_verify_pass();
        doReset();
        pEnable = 1'b1;
        step();
        vecCnt++;
        if (bus.send_v !== 1'b1 || verify_status !== 3'd1 || verify_state !== 3'd1) begin
            errCnt++;
            $display("FAIL pass_send1: got v=%b st=%0d fsm=%0d, want v=1 st=1 fsm=1",
                     bus.send_v, verify_status, verify_state);
        end
        step();
        vecCnt++;
        if (bus.send_v !== 1'b1) begin
            errCnt++;
            $display("FAIL pass_send2: got v=%b, want 1", bus.send_v);
        end
        bus.send_v_ack = 1'b1;
        step();
        bus.send_v_ack = 1'b0;
        vecCnt++;
        if (bus.send_v !== 1'b0 || verify_state !== 3'd2 || verifyCnt !== 3'd1) begin
            errCnt++;
            $display("FAIL pass_ack: got v=%b fsm=%0d cnt=%0d, want v=0 fsm=2 cnt=1",
                     bus.send_v, verify_state, verifyCnt);
        end
        step();
        step();
        bus.rcv_r = 1'b1;
        step();
        bus.rcv_r = 1'b0;
        vecCnt++;
        if (verify_state !== 3'd3 || pActive !== 1'b1 || verify_status !== 3'd2 || verifyCnt !== 3'd1) begin
            errCnt++;
            $display("FAIL pass_verified: got fsm=%0d act=%b st=%0d cnt=%0d, want fsm=3 act=1 st=2 cnt=1",
                     verify_state, pActive, verify_status, verifyCnt);
        end
    endtask

    task automatic test_verify_fail();
        int rises = 0;
        int lastRise = -100;
        logic prevV = 1'b0;
        doReset();
        pEnable = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            step();
            if (bus.send_v === 1'b1 && prevV === 1'b0) begin
                rises++;
                if (rises > 1) begin
                    vecCnt++;
                    if (cyc - lastRise < 8) begin
                        errCnt++;
                        $display("FAIL fail_spacing: got %0d cycles between requests, want >=8", cyc - lastRise);
                    end
                end
                lastRise = cyc;
            end
            prevV = bus.send_v;
            bus.send_v_ack = bus.send_v;
        end
        bus.send_v_ack = 1'b0;
        vecCnt++;
        if (rises !== 3) begin
            errCnt++;
            $display("FAIL fail_requests: got %0d send_v requests, want 3", rises);
        end
        vecCnt++;
        if (verify_state !== 3'd4 || verify_status !== 3'd3 || pActive !== 1'b0 || verifyCnt !== 3'd3) begin
            errCnt++;
            $display("FAIL fail_final: got fsm=%0d st=%0d act=%b cnt=%0d, want fsm=4 st=3 act=0 cnt=3",
                     verify_state, verify_status, pActive, verifyCnt);
        end
    endtask

    task automatic test_coincident();
        bit reached = 1'b0;
        doReset();
        pEnable = 1'b1;
        for (int cyc = 0; cyc < 60 && !reached; cyc++) begin
            step();
            bus.send_v_ack = bus.send_v;
            if (verify_state === 3'd2 && verifyCnt === 3'd3) reached = 1'b1;
        end
        bus.send_v_ack = 1'b0;
        vecCnt++;
        if (!reached) begin
            errCnt++;
            $display("FAIL coin_third_wait: got fsm=%0d cnt=%0d, want third wait reached", verify_state, verifyCnt);
        end
        // Timer loads to 7 on the ack edge; 7 more edges bring it to 0
        for (int i = 0; i < 7; i++) step();
        vecCnt++;
        if (verify_state !== 3'd2) begin
            errCnt++;
            $display("FAIL coin_pre_timeout: got fsm=%0d, want 2", verify_state);
        end
        bus.rcv_r = 1'b1;
        step();
        bus.rcv_r = 1'b0;
        vecCnt++;
        if (verify_state !== 3'd3 || verify_status !== 3'd2 || pActive !== 1'b1) begin
            errCnt++;
            $display("FAIL coin_verified: got fsm=%0d st=%0d act=%b, want fsm=3 st=2 act=1",
                     verify_state, verify_status, pActive);
        end
    endtask

    task automatic test_link_fail();
        link_fail = 1'b1;
        step();
        link_fail = 1'b0;
        vecCnt++;
        if (verify_state !== 3'd0 || pActive !== 1'b0 || verifyCnt !== 3'd0 || verify_status !== 3'd0) begin
            errCnt++;
            $display("FAIL link_abort: got fsm=%0d act=%b cnt=%0d st=%0d, want all 0",
                     verify_state, pActive, verifyCnt, verify_status);
        end
        step();
        vecCnt++;
        if (bus.send_v !== 1'b1 || verify_state !== 3'd1) begin
            errCnt++;
            $display("FAIL link_resend: got v=%b fsm=%0d, want v=1 fsm=1", bus.send_v, verify_state);
        end
        bus.send_v_ack = 1'b1;
        step();
        bus.send_v_ack = 1'b0;
        vecCnt++;
        if (verifyCnt !== 3'd1 || verify_state !== 3'd2) begin
            errCnt++;
            $display("FAIL link_recount: got cnt=%0d fsm=%0d, want cnt=1 fsm=2", verifyCnt, verify_state);
        end
    endtask

    task automatic test_disabled();
        bit sawV = 1'b0;
        doReset();
        disableVerify = 1'b1;
        pEnable       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.send_v !== 1'b0) sawV = 1'b1;
        end
        vecCnt++;
        if (sawV) begin
            errCnt++;
            $display("FAIL dis_no_send: got send_v asserted, want never");
        end
        vecCnt++;
        if (verify_state !== 3'd5 || verify_status !== 3'd4 || pActive !== 1'b1) begin
            errCnt++;
            $display("FAIL dis_state: got fsm=%0d st=%0d act=%b, want fsm=5 st=4 act=1",
                     verify_state, verify_status, pActive);
        end
        disableVerify = 1'b0;
        step();
        vecCnt++;
        if (verify_state !== 3'd0 || pActive !== 1'b0) begin
            errCnt++;
            $display("FAIL dis_release: got fsm=%0d act=%b, want fsm=0 act=0", verify_state, pActive);
        end
        step();
        disableVerify = 1'b1;
        step();
        vecCnt++;
        if (verify_state !== 3'd5 || bus.send_v !== 1'b0 || verify_status !== 3'd4) begin
            errCnt++;
            $display("FAIL dis_withdraw: got fsm=%0d v=%b st=%0d, want fsm=5 v=0 st=4",
                     verify_state, bus.send_v, verify_status);
        end
    endtask

    task automatic test_respond();
        doReset();
        pEnable       = 1'b1;
        disableVerify = 1'b1;
        bus.rcv_v = 1'b1;
        step();
        vecCnt++;
        if (bus.send_r !== 1'b1) begin
            errCnt++;
            $display("FAIL resp_set: got r=%b, want 1", bus.send_r);
        end
        bus.send_r_ack = 1'b1;
        step();
        bus.rcv_v = 1'b0;
        vecCnt++;
        if (bus.send_r !== 1'b1) begin
            errCnt++;
            $display("FAIL resp_ack_and_rcv: got r=%b, want 1", bus.send_r);
        end
        step();
        bus.send_r_ack = 1'b0;
        vecCnt++;
        if (bus.send_r !== 1'b0) begin
            errCnt++;
            $display("FAIL resp_clear: got r=%b, want 0", bus.send_r);
        end
        bus.rcv_v = 1'b1;
        step();
        step();
        bus.rcv_v      = 1'b0;
        bus.send_r_ack = 1'b1;
        step();
        bus.send_r_ack = 1'b0;
        vecCnt++;
        if (bus.send_r !== 1'b0) begin
            errCnt++;
            $display("FAIL resp_merge: got r=%b, want 0 after single ack", bus.send_r);
        end
        pEnable   = 1'b0;
        bus.rcv_v = 1'b1;
        step();
        bus.rcv_v = 1'b0;
        vecCnt++;
        if (bus.send_r !== 1'b0) begin
            errCnt++;
            $display("FAIL resp_abort_block: got r=%b, want 0", bus.send_r);
        end
    endtask

    task automatic test_reset_mid_wait();
        doReset();
        pEnable = 1'b1;
        step();
        bus.send_v_ack = 1'b1;
        bus.rcv_v      = 1'b1;
        step();
        bus.send_v_ack = 1'b0;
        bus.rcv_v      = 1'b0;
        vecCnt++;
        if (verify_state !== 3'd2 || bus.send_r !== 1'b1 || verifyCnt !== 3'd1) begin
            errCnt++;
            $display("FAIL rst_setup: got fsm=%0d r=%b cnt=%0d, want fsm=2 r=1 cnt=1",
                     verify_state, bus.send_r, verifyCnt);
        end
        step();
        reset_begin = 1'b1;
        step();
        reset_begin = 1'b0;
        vecCnt++;
        if ({bus.send_v, bus.send_r, pActive, verify_status, verifyCnt, verify_state} !== 12'h000) begin
            errCnt++;
            $display("FAIL rst_mid_wait: got v=%b r=%b act=%b st=%0d cnt=%0d fsm=%0d, want all 0",
                     bus.send_v, bus.send_r, pActive, verify_status, verifyCnt, verify_state);
        end
    endtask

    initial begin
        test_reset();
        test_verify_pass();
        test_verify_fail();
        test_coincident();
        test_link_fail();
        test_disabled();
        test_respond();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
